// File: rtl/psram_arb.sv
// Round-robin arbiter and single-outstanding transaction sequencer in front of the PSRAM core.
// One request is granted at a time, issued over valid/ready, and answered with a one-cycle response.
module psram_arb #(
    parameter int unsigned NUM_REQ  = 2,
    parameter int unsigned TO_WIDTH = 16,
    localparam int unsigned IDW     = $clog2(NUM_REQ)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic [TO_WIDTH-1:0]   timeout_i,
    input  logic [NUM_REQ-1:0]    req_valid_i,
    output logic [NUM_REQ-1:0]    req_ready_o,
    input  logic [2*NUM_REQ-1:0]  req_op_i,
    input  logic [32*NUM_REQ-1:0] req_addr_i,
    input  logic [64*NUM_REQ-1:0] req_wdata_i,
    output logic [NUM_REQ-1:0]    rsp_valid_o,
    output logic [63:0]           rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  core_valid_o,
    input  logic                  core_ready_i,
    output logic [1:0]            core_op_o,
    output logic [31:0]           core_addr_o,
    output logic [63:0]           core_wdata_o,
    input  logic                  core_done_i,
    input  logic [63:0]           core_rdata_i,
    output logic                  core_abort_o,
    output logic                  busy_o,
    output logic [IDW-1:0]        gnt_id_o
);

    localparam logic [1:0] OP_READ    = 2'b00;
    localparam logic [1:0] OP_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [IDW-1:0]        last_gnt_q, last_gnt_d;
    logic [IDW-1:0]        gnt_id_q, gnt_id_d;
    logic [TO_WIDTH-1:0]   cnt_q, cnt_d;
    logic [1:0]            op_q, op_d;
    logic [31:0]           addr_q, addr_d;
    logic [63:0]           wdata_q, wdata_d;
    logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
    logic [63:0]           rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  core_valid_q, core_valid_d;
    logic                  core_abort_q, core_abort_d;
    logic                  busy_q, busy_d;

    logic                  win_found;
    logic [IDW-1:0]        win_id;
    logic [1:0]            win_op;
    logic [31:0]           win_addr;
    logic [63:0]           win_wdata;
    logic                  to_hit;

    // Round-robin search starting one past the last requester served
    always_comb begin
        int unsigned idx;
        idx       = 0;
        win_found = 1'b0;
        win_id    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = (32'(last_gnt_q) + 32'd1 + i) % NUM_REQ;
            if (!win_found && req_valid_i[IDW'(idx)]) begin
                win_found = 1'b1;
                win_id    = IDW'(idx);
            end
        end
    end

    assign win_op    = req_op_i[32'(win_id) * 2 +: 2];
    assign win_addr  = req_addr_i[32'(win_id) * 32 +: 32];
    assign win_wdata = req_wdata_i[32'(win_id) * 64 +: 64];
    assign to_hit    = (timeout_i != '0) && (cnt_q == timeout_i - TO_WIDTH'(1));

    always_comb begin
        state_d      = state_q;
        last_gnt_d   = last_gnt_q;
        gnt_id_d     = gnt_id_q;
        cnt_d        = cnt_q;
        op_d         = op_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rsp_valid_d  = '0;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_err_d    = rsp_err_q;
        core_valid_d = core_valid_q;
        core_abort_d = 1'b0;
        req_ready_o  = '0;

        case (state_q)
            S_IDLE: begin
                if (en_i && win_found && !rst_i) begin
                    req_ready_o[win_id] = 1'b1;
                    gnt_id_d = win_id;
                    op_d     = win_op;
                    addr_d   = win_addr;
                    wdata_d  = win_wdata;
                    if (win_op == OP_ILLEGAL) begin
                        // Illegal ops are answered directly without touching the core
                        state_d             = S_RESP;
                        rsp_valid_d[win_id] = 1'b1;
                        rsp_err_d           = 1'b1;
                        rsp_rdata_d         = '0;
                    end else begin
                        state_d      = S_ISSUE;
                        core_valid_d = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if (core_ready_i) begin
                    state_d      = S_WAIT;
                    core_valid_d = 1'b0;
                    cnt_d        = '0;
                end
            end
            S_WAIT: begin
                // Completion takes priority over a timeout landing in the same cycle
                if (core_done_i) begin
                    state_d               = S_RESP;
                    rsp_valid_d[gnt_id_q] = 1'b1;
                    rsp_err_d             = 1'b0;
                    rsp_rdata_d           = (op_q == OP_READ) ? core_rdata_i : '0;
                end else if (to_hit) begin
                    state_d               = S_RESP;
                    rsp_valid_d[gnt_id_q] = 1'b1;
                    rsp_err_d             = 1'b1;
                    rsp_rdata_d           = '0;
                    core_abort_d          = 1'b1;
                end else begin
                    cnt_d = cnt_q + TO_WIDTH'(1);
                end
            end
            S_RESP: begin
                last_gnt_d = gnt_id_q;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            last_gnt_q   <= IDW'(NUM_REQ - 1);
            gnt_id_q     <= '0;
            cnt_q        <= '0;
            op_q         <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rsp_valid_q  <= '0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
            core_valid_q <= 1'b0;
            core_abort_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_gnt_q   <= last_gnt_d;
            gnt_id_q     <= gnt_id_d;
            cnt_q        <= cnt_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_err_q    <= rsp_err_d;
            core_valid_q <= core_valid_d;
            core_abort_q <= core_abort_d;
            busy_q       <= busy_d;
        end
    end

    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_rdata_o  = rsp_rdata_q;
    assign rsp_err_o    = rsp_err_q;
    assign core_valid_o = core_valid_q;
    assign core_op_o    = op_q;
    assign core_addr_o  = addr_q;
    assign core_wdata_o = wdata_q;
    assign core_abort_o = core_abort_q;
    assign busy_o       = busy_q;
    assign gnt_id_o     = gnt_id_q;

endmodule

// File: tb/tb_psram_arb.sv
// Directed bench for psram_arb: per-cycle vector table plus hand-written timeout and reset sequences.
module tb_psram_arb;

    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned TO_W    = 16;

    logic                  clk_i = 1'b0;
    logic                  rst_i;
    logic                  en_i;
    logic [TO_W-1:0]       timeout_i;
    logic [NUM_REQ-1:0]    req_valid_i;
    logic [NUM_REQ-1:0]    req_ready_o;
    logic [2*NUM_REQ-1:0]  req_op_i;
    logic [32*NUM_REQ-1:0] req_addr_i;
    logic [64*NUM_REQ-1:0] req_wdata_i;
    logic [NUM_REQ-1:0]    rsp_valid_o;
    logic [63:0]           rsp_rdata_o;
    logic                  rsp_err_o;
    logic                  core_valid_o;
    logic                  core_ready_i;
    logic [1:0]            core_op_o;
    logic [31:0]           core_addr_o;
    logic [63:0]           core_wdata_o;
    logic                  core_done_i;
    logic [63:0]           core_rdata_i;
    logic                  core_abort_o;
    logic                  busy_o;
    logic                  gnt_id_o;

    psram_arb #(.NUM_REQ(NUM_REQ), .TO_WIDTH(TO_W)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .en_i         (en_i),
        .timeout_i    (timeout_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_op_i     (req_op_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_rdata_o  (rsp_rdata_o),
        .rsp_err_o    (rsp_err_o),
        .core_valid_o (core_valid_o),
        .core_ready_i (core_ready_i),
        .core_op_o    (core_op_o),
        .core_addr_o  (core_addr_o),
        .core_wdata_o (core_wdata_o),
        .core_done_i  (core_done_i),
        .core_rdata_i (core_rdata_i),
        .core_abort_o (core_abort_o),
        .busy_o       (busy_o),
        .gnt_id_o     (gnt_id_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0]  valid;
        logic [3:0]  op;
        logic        en;
        logic        cready;
        logic        cdone;
        logic [63:0] crdata;
        logic [1:0]  e_ready;
        logic [1:0]  e_rspv;
        logic        e_cval;
        logic        e_busy;
        logic        e_gnt;
        logic        e_err;
        logic [63:0] e_rdata;
    } vec_t;

    vec_t tbl[$];
    int   errors = 0;
    int   checks = 0;

    localparam logic [63:0] RD_A = 64'hDEADBEEF_CAFEF00D;
    localparam logic [63:0] RD_C = 64'h11223344_55667788;
    localparam logic [63:0] RD_D = 64'hA5A5A5A5_5A5A5A5A;
    localparam logic [63:0] ONES = 64'hFFFFFFFF_FFFFFFFF;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [1:0] v, input logic [3:0] op, input logic en, input logic cr,
                       input logic cd, input logic [63:0] crd, input logic [1:0] er,
                       input logic [1:0] ers, input logic ecv, input logic eb, input logic eg,
                       input logic eerr, input logic [63:0] erd);
        vec_t r;
        r.valid = v;  r.op = op;  r.en = en;  r.cready = cr;  r.cdone = cd;  r.crdata = crd;
        r.e_ready = er;  r.e_rspv = ers;  r.e_cval = ecv;  r.e_busy = eb;
        r.e_gnt = eg;  r.e_err = eerr;  r.e_rdata = erd;
        tbl.push_back(r);
    endtask

    function automatic logic [127:0] obs();
        return 128'({req_ready_o, rsp_valid_o, core_valid_o, busy_o, gnt_id_o,
                     rsp_err_o, core_abort_o, rsp_rdata_o});
    endfunction

    task automatic build_table();
        logic       g;
        logic       prev_g;
        logic [1:0] oh;
        logic [63:0] prev_rd;
        // single read from requester 0, done three cycles after ready
        add(2'b00, 4'b0000, 1, 0, 0, 64'd0, 2'b00, 2'b00, 0, 0, 0, 0, 64'd0);
        add(2'b01, 4'b0000, 1, 0, 0, 64'd0, 2'b01, 2'b00, 0, 0, 0, 0, 64'd0);
        add(2'b00, 4'b0000, 1, 1, 0, 64'd0, 2'b00, 2'b00, 1, 1, 0, 0, 64'd0);
        add(2'b00, 4'b0000, 1, 0, 0, 64'd0, 2'b00, 2'b00, 0, 1, 0, 0, 64'd0);
        add(2'b00, 4'b0000, 1, 0, 0, 64'd0, 2'b00, 2'b00, 0, 1, 0, 0, 64'd0);
        add(2'b00, 4'b0000, 1, 0, 1, RD_A,  2'b00, 2'b00, 0, 1, 0, 0, 64'd0);
        add(2'b00, 4'b0000, 1, 0, 0, 64'd0, 2'b00, 2'b01, 0, 1, 0, 0, RD_A);
        add(2'b00, 4'b0000, 1, 0, 0, 64'd0, 2'b00, 2'b00, 0, 0, 0, 0, RD_A);
        // both requesters hold writes; grants alternate, write responses carry zero data
        prev_g  = 1'b0;
        prev_rd = RD_A;
        for (int k = 0; k < 4; k++) begin
            g  = (k % 2 == 0) ? 1'b1 : 1'b0;
            oh = g ? 2'b10 : 2'b01;
            add(2'b11, 4'b0101, 1, 1, 1, ONES, oh,    2'b00, 0, 0, prev_g, 0, prev_rd);
            add(2'b11, 4'b0101, 1, 1, 1, ONES, 2'b00, 2'b00, 1, 1, g,      0, prev_rd);
            add(2'b11, 4'b0101, 1, 1, 1, ONES, 2'b00, 2'b00, 0, 1, g,      0, prev_rd);
            add(2'b11, 4'b0101, 1, 1, 1, ONES, 2'b00, oh,    0, 1, g,      0, 64'd0);
            prev_g  = g;
            prev_rd = 64'd0;
        end
        // illegal op from requester 1, then a normal read from requester 0
        add(2'b10, 4'b1100, 1, 0, 0, 64'd0, 2'b10, 2'b00, 0, 0, 0, 0, 64'd0);
        add(2'b01, 4'b0000, 1, 0, 0, 64'd0, 2'b00, 2'b10, 0, 1, 1, 1, 64'd0);
        add(2'b01, 4'b0000, 1, 0, 0, 64'd0, 2'b01, 2'b00, 0, 0, 1, 1, 64'd0);
        add(2'b00, 4'b0000, 1, 1, 0, 64'd0, 2'b00, 2'b00, 1, 1, 0, 1, 64'd0);
        add(2'b00, 4'b0000, 1, 0, 1, RD_C,  2'b00, 2'b00, 0, 1, 0, 1, 64'd0);
        add(2'b00, 4'b0000, 1, 0, 0, 64'd0, 2'b00, 2'b01, 0, 1, 0, 0, RD_C);
        add(2'b00, 4'b0000, 1, 0, 0, 64'd0, 2'b00, 2'b00, 0, 0, 0, 0, RD_C);
        // enable low blocks grants; dropping it mid-flight still lets the response through
        add(2'b11, 4'b0000, 0, 0, 0, 64'd0, 2'b00, 2'b00, 0, 0, 0, 0, RD_C);
        add(2'b11, 4'b0000, 0, 0, 0, 64'd0, 2'b00, 2'b00, 0, 0, 0, 0, RD_C);
        add(2'b01, 4'b0000, 1, 0, 0, 64'd0, 2'b01, 2'b00, 0, 0, 0, 0, RD_C);
        add(2'b00, 4'b0000, 0, 1, 0, 64'd0, 2'b00, 2'b00, 1, 1, 0, 0, RD_C);
        add(2'b00, 4'b0000, 0, 0, 0, 64'd0, 2'b00, 2'b00, 0, 1, 0, 0, RD_C);
        add(2'b00, 4'b0000, 0, 0, 1, RD_D,  2'b00, 2'b00, 0, 1, 0, 0, RD_C);
        add(2'b00, 4'b0000, 0, 0, 0, 64'd0, 2'b00, 2'b01, 0, 1, 0, 0, RD_D);
        add(2'b11, 4'b0000, 0, 0, 0, 64'd0, 2'b00, 2'b00, 0, 0, 0, 0, RD_D);
    endtask

    initial begin
        logic stuck_ok;
        rst_i        = 1'b1;
        en_i         = 1'b1;
        timeout_i    = '0;
        req_valid_i  = 2'b11;
        req_op_i     = 4'b0000;
        req_addr_i   = {32'h0000_0200, 32'h0000_0100};
        req_wdata_i  = {64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        core_ready_i = 1'b0;
        core_done_i  = 1'b0;
        core_rdata_i = '0;
        build_table();

        repeat (2) @(negedge clk_i);
        #1;
        check("reset_outputs", obs(), 128'd0);
        check("reset_core_fields", 128'({core_op_o, core_addr_o, core_wdata_o}), 128'd0);
        @(negedge clk_i);
        rst_i       = 1'b0;
        req_valid_i = 2'b00;

        foreach (tbl[i]) begin
            @(negedge clk_i);
            req_valid_i  = tbl[i].valid;
            req_op_i     = tbl[i].op;
            en_i         = tbl[i].en;
            core_ready_i = tbl[i].cready;
            core_done_i  = tbl[i].cdone;
            core_rdata_i = tbl[i].crdata;
            #1;
            check($sformatf("vec%0d", i), obs(),
                  128'({tbl[i].e_ready, tbl[i].e_rspv, tbl[i].e_cval, tbl[i].e_busy,
                        tbl[i].e_gnt, tbl[i].e_err, 1'b0, tbl[i].e_rdata}));
        end

        // timeout of 5 with the core never finishing
        timeout_i = 16'd5;
        @(negedge clk_i);
        req_valid_i = 2'b01; req_op_i = 4'b0000; en_i = 1'b1;
        core_ready_i = 1'b0; core_done_i = 1'b0; core_rdata_i = ONES;
        #1 check("to5_accept", 128'(req_ready_o), 128'(2'b01));
        @(negedge clk_i);
        req_valid_i = 2'b00; core_ready_i = 1'b1;
        #1 check("to5_issue", 128'({core_valid_o, core_op_o, core_addr_o}), 128'({1'b1, 2'b00, 32'h100}));
        @(negedge clk_i);
        core_ready_i = 1'b0;
        for (int k = 0; k <= 6; k++) begin
            if (k > 0) @(negedge clk_i);
            #1;
            check($sformatf("to5_k%0d", k), 128'({core_abort_o, rsp_valid_o}),
                  (k == 5) ? 128'(3'b101) : 128'(3'b000));
            if (k == 5) check("to5_rsp", 128'({rsp_err_o, rsp_rdata_o}), 128'({1'b1, 64'd0}));
        end

        // timeout disabled: transaction parks in WAIT
        timeout_i = '0;
        @(negedge clk_i);
        req_valid_i = 2'b01;
        @(negedge clk_i);
        req_valid_i = 2'b00; core_ready_i = 1'b1;
        @(negedge clk_i);
        core_ready_i = 1'b0;
        stuck_ok = 1'b1;
        repeat (120) begin
            #1;
            if (!(busy_o && rsp_valid_o == 2'b00 && !core_abort_o)) stuck_ok = 1'b0;
            @(negedge clk_i);
        end
        check("to0_stuck", 128'(stuck_ok), 128'(1'b1));
        core_done_i = 1'b1; core_rdata_i = 64'h0123_4567_89AB_CDEF;
        @(negedge clk_i);
        core_done_i = 1'b0;
        #1 check("to0_resp", 128'({rsp_valid_o, rsp_err_o, rsp_rdata_o}),
                 128'({2'b01, 1'b0, 64'h0123_4567_89AB_CDEF}));

        // done in the same cycle the timeout would fire
        timeout_i = 16'd4;
        @(negedge clk_i);
        req_valid_i = 2'b01;
        @(negedge clk_i);
        req_valid_i = 2'b00; core_ready_i = 1'b1;
        @(negedge clk_i);
        core_ready_i = 1'b0;
        repeat (3) @(negedge clk_i);
        core_done_i = 1'b1; core_rdata_i = 64'h0F0F_0F0F_F0F0_F0F0;
        @(negedge clk_i);
        core_done_i = 1'b0;
        #1 check("to4_done_wins", 128'({core_abort_o, rsp_valid_o, rsp_err_o, rsp_rdata_o}),
                 128'({1'b0, 2'b01, 1'b0, 64'h0F0F_0F0F_F0F0_F0F0}));

        // reset during ISSUE, then requester 0 must win first
        @(negedge clk_i);
        req_valid_i = 2'b11;
        #1 check("rr_pick1", 128'(req_ready_o), 128'(2'b10));
        @(negedge clk_i);
        req_valid_i = 2'b01;
        #1 check("rst_pre", 128'({core_valid_o, gnt_id_o}), 128'(2'b11));
        #2 rst_i = 1'b1;
        #1;
        check("rst_async", obs(), 128'd0);
        check("rst_async_fields", 128'({core_op_o, core_addr_o, core_wdata_o}), 128'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        req_valid_i = 2'b11;
        #1 check("rst_rr0", 128'(req_ready_o), 128'(2'b01));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
